// File: rtl/rpsc_fault_latch_if.sv
// Fault-latch card signal bundle: field inputs, operator ack, and latched fault status.
// The slave modport is the card itself; master is the side driving the field inputs.
interface rpsc_fault_latch_if #(
    parameter int N_CH = 6
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] fault_in_b;
    logic [N_CH-1:0] mask;
    logic            ack_b;
    logic [N_CH-1:0] ff_out;
    logic            any_fault;
    logic            alarm_b;
    logic [1:0]      state;
    logic [IW-1:0]   first_fault_idx;
    logic            first_fault_vld;

    modport master (
        output fault_in_b, mask, ack_b,
        input  ff_out, any_fault, alarm_b, state, first_fault_idx, first_fault_vld
    );

    modport slave (
        input  fault_in_b, mask, ack_b,
        output ff_out, any_fault, alarm_b, state, first_fault_idx, first_fault_vld
    );
endinterface

// File: rtl/rpsc_fault_latch.sv
// RF-permit fault latch: synchronize, debounce and latch N active-low faults, with ack/clear FSM.
// Optional first-fault capture is enabled by defining RPSC_FIRST_FAULT_EN.
module rpsc_fault_latch #(
    parameter int N_CH     = 6,
    parameter int DEBOUNCE = 4,
    parameter int ACK_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset_b,
    rpsc_fault_latch_if.slave   bus
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(ACK_HOLD + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_SET = CW'(DEBOUNCE - 1);
    localparam logic [AW-1:0] AH_MAX = AW'(ACK_HOLD);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'b00,
        ST_TRIPPED  = 2'b01,
        ST_ACK_WAIT = 2'b10
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N_CH-1:0] r_flt_s1, r_flt_s2;
    logic            r_ack_s1, r_ack_s2;
    logic [CW-1:0]   r_db_cnt [N_CH];
    logic [AW-1:0]   r_ack_cnt, w_ack_cnt_nxt, w_ack_inc;
    logic [N_CH-1:0] r_ff, w_qual, w_set, w_clr, w_ff_nxt;

    // A channel qualifies on the edge its counter reaches DEBOUNCE; set beats clear.
    always_comb begin
        w_qual = ~r_flt_s2 & ~bus.mask;
        w_set  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_set[i] = w_qual[i] && (r_db_cnt[i] >= DB_SET);
        end
        w_clr    = (r_state == ST_ACK_WAIT && r_ack_s2) ? (r_flt_s2 | bus.mask) : '0;
        w_ff_nxt = (r_ff & ~w_clr) | w_set;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ack_cnt_nxt = '0;
        w_ack_inc     = r_ack_cnt + 1'b1;
        case (r_state)
            ST_ARMED: begin
                if (|r_ff) w_state_nxt = ST_TRIPPED;
            end
            ST_TRIPPED: begin
                if (!r_ack_s2) begin
                    if (w_ack_inc == AH_MAX) w_state_nxt = ST_ACK_WAIT;
                    else                     w_ack_cnt_nxt = w_ack_inc;
                end
            end
            ST_ACK_WAIT: begin
                if (r_ack_s2) w_state_nxt = (|w_ff_nxt) ? ST_TRIPPED : ST_ARMED;
            end
            default: w_state_nxt = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) r_state <= ST_ARMED;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_flt_s1  <= '1;
            r_flt_s2  <= '1;
            r_ack_s1  <= 1'b1;
            r_ack_s2  <= 1'b1;
            r_ack_cnt <= '0;
            r_ff      <= '0;
            for (int i = 0; i < N_CH; i++) r_db_cnt[i] <= '0;
        end else begin
            r_flt_s1  <= bus.fault_in_b;
            r_flt_s2  <= r_flt_s1;
            r_ack_s1  <= bus.ack_b;
            r_ack_s2  <= r_ack_s1;
            r_ack_cnt <= w_ack_cnt_nxt;
            r_ff      <= w_ff_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (!w_qual[i])              r_db_cnt[i] <= '0;
                else if (r_db_cnt[i] != DB_MAX) r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
        end
    end

    assign bus.ff_out    = r_ff;
    assign bus.any_fault = |r_ff;
    assign bus.alarm_b   = ~(|r_ff);
    assign bus.state     = r_state;

`ifdef RPSC_FIRST_FAULT_EN
    logic [IW-1:0] r_ffi, w_low_idx;
    logic          r_ffv;

    always_comb begin
        w_low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_ff_nxt[i]) w_low_idx = IW'(i);
        end
    end

    // Index is kept after the valid drops so the operator can still read it.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_ffi <= '0;
            r_ffv <= 1'b0;
        end else if (!r_ffv && (r_ff == '0) && (w_ff_nxt != '0)) begin
            r_ffi <= w_low_idx;
            r_ffv <= 1'b1;
        end else if (r_state != ST_ARMED && w_state_nxt == ST_ARMED) begin
            r_ffv <= 1'b0;
        end
    end

    assign bus.first_fault_idx = r_ffi;
    assign bus.first_fault_vld = r_ffv;
`else
    assign bus.first_fault_idx = {IW{1'b0}};
    assign bus.first_fault_vld = 1'b0;
`endif
endmodule

// File: tb/tb_rpsc_fault_latch.sv
// Directed bench for rpsc_fault_latch; expectations queued with a due cycle and checked on arrival.
module tb_rpsc_fault_latch;
    localparam int N = 6;
`ifdef RPSC_FIRST_FAULT_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif
    localparam logic [1:0] ARM = 2'b00, TRIP = 2'b01, ACKW = 2'b10;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    rpsc_fault_latch_if #(.N_CH(N)) bus ();

    rpsc_fault_latch #(.N_CH(N), .DEBOUNCE(4), .ACK_HOLD(8)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    typedef struct {
        int         due;
        string      tag;
        logic [5:0] ff;
        logic [1:0] st;
        logic [2:0] idx;
        logic       vld;
    } exp_t;

    exp_t sb[$];
    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    task automatic exp_at(input int d, input string tag, input logic [5:0] ff,
                          input logic [1:0] st, input logic [2:0] idx, input logic vld);
        exp_t e;
        e.due = cyc + d;
        e.tag = tag;
        e.ff  = ff;
        e.st  = st;
        e.idx = FF_EN ? idx : 3'd0;
        e.vld = FF_EN ? vld : 1'b0;
        sb.push_back(e);
    endtask

    task automatic cmp(input exp_t e);
        total++;
        assert (bus.ff_out === e.ff) else begin
            bad++; $error("FAIL %s ff_out got=%b want=%b", e.tag, bus.ff_out, e.ff);
        end
        total++;
        assert (bus.alarm_b === ~(|e.ff)) else begin
            bad++; $error("FAIL %s alarm_b got=%b want=%b", e.tag, bus.alarm_b, ~(|e.ff));
        end
        total++;
        assert (bus.any_fault === (|e.ff)) else begin
            bad++; $error("FAIL %s any_fault got=%b want=%b", e.tag, bus.any_fault, |e.ff);
        end
        total++;
        assert (bus.state === e.st) else begin
            bad++; $error("FAIL %s state got=%b want=%b", e.tag, bus.state, e.st);
        end
        total++;
        assert (bus.first_fault_idx === e.idx) else begin
            bad++; $error("FAIL %s first_fault_idx got=%0d want=%0d", e.tag, bus.first_fault_idx, e.idx);
        end
        total++;
        assert (bus.first_fault_vld === e.vld) else begin
            bad++; $error("FAIL %s first_fault_vld got=%b want=%b", e.tag, bus.first_fault_vld, e.vld);
        end
    endtask

    task automatic drain();
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == cyc) begin
                cmp(sb[k]);
                sb.delete(k);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            drain();
        end
    endtask

    task automatic ack_press(input int len);
        bus.ack_b = 1'b0;
        step(len);
        bus.ack_b = 1'b1;
    endtask

    initial begin
        reset_b        = 1'b0;
        bus.fault_in_b = '1;
        bus.mask       = '0;
        bus.ack_b      = 1'b1;

        exp_at(2, "reset", 6'b0, ARM, 3'd0, 1'b0);
        step(2);
        reset_b = 1'b1;
        for (int k = 1; k <= 20; k++) exp_at(k, "idle", 6'b0, ARM, 3'd0, 1'b0);
        step(20);

        // 3-cycle glitch on channel 1
        bus.fault_in_b[1] = 1'b0;
        exp_at(6, "glitch3_e5", 6'b0, ARM, 3'd0, 1'b0);
        exp_at(10, "glitch3", 6'b0, ARM, 3'd0, 1'b0);
        step(3);
        bus.fault_in_b[1] = 1'b1;
        step(7);

        // masked channel 5 held low
        bus.mask[5] = 1'b1;
        bus.fault_in_b[5] = 1'b0;
        exp_at(6, "mask_e5", 6'b0, ARM, 3'd0, 1'b0);
        exp_at(20, "mask_hold", 6'b0, ARM, 3'd0, 1'b0);
        step(20);
        bus.fault_in_b[5] = 1'b1;
        step(3);
        bus.mask[5] = 1'b0;
        step(1);

        // pulse of exactly DEBOUNCE cycles latches
        bus.fault_in_b[0] = 1'b0;
        exp_at(5, "pulse4_pre", 6'b0, ARM, 3'd0, 1'b0);
        exp_at(6, "pulse4", 6'b000001, ARM, 3'd0, 1'b1);
        exp_at(7, "pulse4_trip", 6'b000001, TRIP, 3'd0, 1'b1);
        step(4);
        bus.fault_in_b[0] = 1'b1;
        step(3);
        exp_at(10, "clr0_wait", 6'b000001, ACKW, 3'd0, 1'b1);
        exp_at(11, "clr0", 6'b0, ARM, 3'd0, 1'b0);
        ack_press(8);
        step(3);

        // basic latch on channel 3
        bus.fault_in_b[3] = 1'b0;
        exp_at(5, "latch_pre", 6'b0, ARM, 3'd0, 1'b0);
        exp_at(6, "latch", 6'b001000, ARM, 3'd3, 1'b1);
        exp_at(7, "trip", 6'b001000, TRIP, 3'd3, 1'b1);
        step(8);

        // ack with the fault released clears
        bus.fault_in_b[3] = 1'b1;
        exp_at(9, "ack_hold", 6'b001000, TRIP, 3'd3, 1'b1);
        exp_at(10, "ack_wait", 6'b001000, ACKW, 3'd3, 1'b1);
        exp_at(11, "ack_clr", 6'b0, ARM, 3'd3, 1'b0);
        ack_press(8);
        step(4);

        // ack with the fault still active keeps it latched
        bus.fault_in_b[3] = 1'b0;
        exp_at(5, "relatch_pre", 6'b0, ARM, 3'd3, 1'b0);
        exp_at(6, "relatch", 6'b001000, ARM, 3'd3, 1'b1);
        exp_at(7, "relatch_trip", 6'b001000, TRIP, 3'd3, 1'b1);
        step(8);
        exp_at(10, "ackact_wait", 6'b001000, ACKW, 3'd3, 1'b1);
        exp_at(11, "ackact_back", 6'b001000, TRIP, 3'd3, 1'b1);
        ack_press(8);
        step(4);

        // one cycle too short
        exp_at(12, "ack7", 6'b001000, TRIP, 3'd3, 1'b1);
        ack_press(7);
        step(5);

        // reset mid-trip, fault still present
        reset_b = 1'b0;
        exp_at(1, "rst_mid", 6'b0, ARM, 3'd0, 1'b0);
        step(1);
        reset_b = 1'b1;
        exp_at(5, "rst_pre", 6'b0, ARM, 3'd0, 1'b0);
        exp_at(6, "rst_relatch", 6'b001000, ARM, 3'd3, 1'b1);
        exp_at(7, "rst_trip", 6'b001000, TRIP, 3'd3, 1'b1);
        step(7);
        bus.fault_in_b[3] = 1'b1;
        exp_at(11, "clr3", 6'b0, ARM, 3'd3, 1'b0);
        ack_press(8);
        step(3);

        // simultaneous first faults, later fault, mask on latched bit
        bus.fault_in_b[2] = 1'b0;
        bus.fault_in_b[4] = 1'b0;
        exp_at(6, "dual", 6'b010100, ARM, 3'd2, 1'b1);
        exp_at(7, "dual_trip", 6'b010100, TRIP, 3'd2, 1'b1);
        step(8);
        bus.fault_in_b[0] = 1'b0;
        exp_at(6, "later0", 6'b010101, TRIP, 3'd2, 1'b1);
        step(6);
        bus.mask[2] = 1'b1;
        exp_at(3, "mask_latched", 6'b010101, TRIP, 3'd2, 1'b1);
        step(3);
        bus.fault_in_b = '1;
        exp_at(11, "clr_all", 6'b0, ARM, 3'd2, 1'b0);
        ack_press(8);
        step(3);
        bus.mask = '0;

        // ack ignored while armed
        exp_at(14, "armed_ack", 6'b0, ARM, 3'd2, 1'b0);
        ack_press(10);
        step(4);

        total++;
        assert (sb.size() == 0) else begin
            bad += sb.size();
            $error("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
